// File: rtl/norm1_mul_share_arb.sv
// Round-robin shared 44x6 unsigned multiplier for the norm1 LRN stages.
// One requester is granted per cycle; its product lands in a single tagged output slot.
module norm1_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 44,
  parameter int B_W     = 6,
  parameter int P_W     = 50
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy,
  output logic                   dbg_full_o,
  output logic [ID_W-1:0]        dbg_rr_ptr_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. req_ready is combinational and one-hot (or zero); rsp_valid is the
  // slot state and rsp_data/rsp_id stay stable until rsp_ready accepts them.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e     state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [P_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            can_accept;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] win_idx;
  int              cand;
  logic [A_W-1:0]  a_sel;
  logic [B_W-1:0]  b_sel;
  logic [P_W-1:0]  product;

  // Walk the requesters starting just after the last winner, wrapping at NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (cand == i) && req_valid[i]) begin
          found   = 1'b1;
          win_idx = ID_W'(i);
        end
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign grant      = can_accept && found && !ap_rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready = NUM_REQ'(1) << win_idx;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  // Both operands are zero-extended to the full product width, so nothing is truncated.
  assign product = P_W'(a_sel) * P_W'(b_sel);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      EMPTY: begin
        if (grant) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (rsp_ready && !grant) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (grant) begin
      rr_ptr_d   = win_idx;
      rsp_data_d = product;
      rsp_id_d   = win_idx;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;
  assign busy         = rsp_valid || (|req_valid);
  assign dbg_full_o   = (state_q == FULL);
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_norm1_mul_share_arb.sv
// Bench for norm1_mul_share_arb: scenario tasks plus a scoreboard that queues
// expected {id, product} on each grant and compares on each output handshake.
module tb_norm1_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 44;
  localparam int B_W     = 6;
  localparam int P_W     = 50;
  localparam int E_W     = ID_W + P_W;

  logic                   ap_clk;
  logic                   ap_rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [P_W-1:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;
  logic                   dbg_full_o;
  logic [ID_W-1:0]        dbg_rr_ptr_o;

  int errors = 0;
  int checks = 0;
  logic [E_W-1:0] exp_q[$];

  norm1_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .dbg_full_o(dbg_full_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [P_W-1:0] model_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[P_W-1:0];
  endfunction

  // scoreboard: pop on output handshake first, then push the grant of this cycle
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=%0h, required no output", rsp_id, rsp_data);
        end else begin
          logic [E_W-1:0] e;
          e = exp_q.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            errors++;
            $display("FAIL rsp_data: got id=%0d data=%0h, required id=%0d data=%0h",
                     rsp_id, rsp_data, e[E_W-1:P_W], e[P_W-1:0]);
          end
        end
      end
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          errors++;
          $display("FAIL grant_onehot: got req_ready=%b, required one-hot within req_valid=%b",
                   req_ready, req_valid);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            exp_q.push_back({ID_W'(i), model_mul(req_a[i*A_W +: A_W], req_b[i*B_W +: B_W])});
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
    req_valid[i]        = 1'b1;
  endtask

  task automatic rand_req(input int i);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    set_req(i, r[A_W-1:0], B_W'($urandom_range(0, 63)));
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_reset();
    ap_rst    = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, A_W'(i + 7), B_W'(i + 3));
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
        errors++;
        $display("FAIL reset_state: got ready=%b valid=%b data=%0h, required 0/0/0",
                 req_ready, rsp_valid, rsp_data);
      end
    end
    checks++;
    if (dbg_rr_ptr_o !== ID_W'(NUM_REQ - 1)) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %0d, required %0d", dbg_rr_ptr_o, NUM_REQ - 1);
    end
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 50'd21) begin
      errors++;
      $display("FAIL reset_first_rsp: got valid=%b id=%0d data=%0d, required 1/0/21",
               rsp_valid, rsp_id, rsp_data);
    end
    drain();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(1, 44'd1000, 6'd63);
    @(negedge ap_clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b, required 0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_data !== 50'd63000 || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL single_rsp: got ready=%b valid=%b data=%0d id=%0d, required 0000/1/63000/1",
               req_ready, rsp_valid, rsp_data, rsp_id);
    end
    tick();
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: got valid=%b busy=%b, required 0/0", rsp_valid, busy);
    end
    drain();
  endtask

  task automatic test_round_robin();
    ap_rst = 1'b1;
    tick();
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rand_req(i);
    for (int k = 0; k < 2 * NUM_REQ; k++) begin
      @(negedge ap_clk);
      checks++;
      if (req_ready !== (4'b0001 << (k % NUM_REQ))) begin
        errors++;
        $display("FAIL rr_order: step %0d got %b, required %b", k, req_ready, 4'b0001 << (k % NUM_REQ));
      end
      tick();
      rand_req(k % NUM_REQ);
    end
    req_valid = '0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [P_W-1:0] held;
    rsp_ready = 1'b1;
    set_req(2, 44'h123_4567_89AB, 6'd45);
    held = model_mul(44'h123_4567_89AB, 6'd45);
    @(negedge ap_clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b, required 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    rsp_ready    = 1'b0;
    set_req(3, 44'd77, 6'd9);
    set_req(0, 44'd5, 6'd11);
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== held) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d got ready=%b valid=%b id=%0d data=%0h, required 0000/1/2/%0h",
                 k, req_ready, rsp_valid, rsp_id, rsp_data, held);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_grant: got %b, required 1000", req_ready);
    end
    tick();
    req_valid[3] = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 50'd693) begin
      errors++;
      $display("FAIL b2b: got ready=%b valid=%b id=%0d data=%0d, required 0001/1/3/693",
               req_ready, rsp_valid, rsp_id, rsp_data);
    end
    tick();
    req_valid[0] = 1'b0;
    drain();
  endtask

  task automatic test_width_boundary();
    logic [A_W-1:0] ones_a;
    logic [P_W-1:0] ones_p;
    ones_a = '1;
    ones_p = model_mul(ones_a, 6'h3F);
    rsp_ready = 1'b1;
    set_req(0, ones_a, 6'h3F);
    tick();
    set_req(0, 44'd0, 6'd63);
    @(negedge ap_clk);
    checks++;
    if (rsp_data !== ones_p) begin
      errors++;
      $display("FAIL width_max: got %0h, required %0h", rsp_data, ones_p);
    end
    tick();
    set_req(0, 44'd5, 6'd0);
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== '0) begin
      errors++;
      $display("FAIL width_zero_a: got valid=%b data=%0h, required 1/0", rsp_valid, rsp_data);
    end
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== '0) begin
      errors++;
      $display("FAIL width_zero_b: got valid=%b data=%0h, required 1/0", rsp_valid, rsp_data);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    rsp_ready = 1'b1;
    set_req(1, 44'd999, 6'd2);
    tick();
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b0;
    tick();
    tick();
    ap_rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, A_W'(100 + i), B_W'(2));
    @(negedge ap_clk);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL rst_stall_ready: got %b, required 0000", req_ready);
    end
    tick();
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_stall_restart: got valid=%b ready=%b, required 0/0001", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 50'd200) begin
      errors++;
      $display("FAIL rst_stall_rsp: got valid=%b id=%0d data=%0d, required 1/0/200",
               rsp_valid, rsp_id, rsp_data);
    end
    drain();
  endtask

  initial begin
    ap_rst    = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_width_boundary();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
